inst_fetch_ctrl: RTL
====================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 fetch_en  in  1  pipeline permits a new fetch to start.
REQ-005 stall  in  1  downstream cannot accept the presented instruction this cycle.
REQ-006 flush  in  1  redirect; discards all in-flight and held instructions.
REQ-007 flush_pc  in  32  redirect target, sampled when flush=1.
REQ-008 inst_req  out  1  SRAM-like request strobe.
REQ-009 inst_addr  out  32  request address.
REQ-010 inst_addr_ok  in  1  request accepted by memory.
REQ-011 inst_data_ok  in  1  read data valid.
REQ-012 inst_rdata  in  32  read data.
REQ-013 if_valid  out  1  an instruction is presented downstream.
REQ-014 if_pc  out  32  PC of the presented instruction.
REQ-015 if_inst  out  32  presented instruction word.
REQ-016 if_unaligned  out  1  presented PC has pc[1:0]!=0 (AdEL); if_inst=0.

Function
REQ-017 The block SHALL hold a 32-bit pc register and an FSM with states IDLE, REQ, WAIT, DISCARD, HOLD.
REQ-018 IDLE: when fetch_en=1, flush=0 and pc[1:0]=0, the next state SHALL be REQ.
REQ-019 IDLE with pc[1:0]!=0: no request; the block SHALL assert if_valid=1, if_unaligned=1, if_inst=0 and if_pc=pc until a flush arrives.
REQ-020 REQ: inst_req=1 and inst_addr=pc, both held stable until inst_addr_ok=1; on addr_ok the next state SHALL be WAIT.
REQ-021 WAIT: on inst_data_ok, the block SHALL present if_valid=1 and if_inst=inst_rdata in the same cycle (combinational pass-through).
REQ-022 WAIT with data_ok and stall=0: pc SHALL become pc+4 (modulo 2^32, wrapping to 0), and the next state SHALL be IDLE.
REQ-023 WAIT with data_ok and stall=1: inst_rdata SHALL be captured into a hold buffer, and the next state SHALL be HOLD.
REQ-024 HOLD: the block SHALL present if_valid=1 with the buffered word; when stall=0, pc SHALL become pc+4 and the next state SHALL be IDLE.
REQ-025 Flush in IDLE or HOLD: pc SHALL become flush_pc, any held word SHALL be dropped, and the next state SHALL be IDLE.
REQ-026 Flush in REQ: inst_req and inst_addr SHALL stay stable; a drop flag SHALL be set and pc SHALL become flush_pc; on addr_ok the next state SHALL be DISCARD.
REQ-027 Flush in REQ coincident with addr_ok: pc SHALL become flush_pc and the next state SHALL be DISCARD.
REQ-028 Flush in WAIT without data_ok: pc SHALL become flush_pc and the next state SHALL be DISCARD.
REQ-029 Flush in WAIT with data_ok in the same cycle: the data SHALL be dropped (if_valid=0), pc SHALL become flush_pc, and the next state SHALL be IDLE.
REQ-030 DISCARD: if_valid=0; on data_ok the response SHALL be dropped and the next state SHALL be IDLE; a flush in DISCARD SHALL only update pc.
REQ-031 At most one request SHALL be outstanding; inst_req SHALL be 0 in every state except REQ.
REQ-032 if_valid SHALL be 0 whenever flush=1.

Reset
REQ-033 On rst=1, the block SHALL set state=IDLE, pc=RESET_PC, the drop flag to 0 and the hold buffer to 0.
REQ-034 During and directly after reset, the block SHALL drive inst_req=0, if_valid=0, if_unaligned=0, if_inst=0 and if_pc=RESET_PC.
REQ-035 Reset while a request is in flight SHALL abandon it; no later data_ok SHALL be presented downstream.

Structure
REQ-036 FSM state encoding and RESET_PC default SHALL live in the shared core package.
REQ-037 The block SHALL be a single module with no sub-modules; the downstream data-holding register is a separate block.

Verification
REQ-038 Reset release, fetch_en=1, addr_ok in cycle 1, data_ok in cycle 3 with rdata=32'h2408_0001 -> req addr BFC00000; if_valid in cycle 3 with if_pc=BFC00000; next req addr BFC00004.
REQ-039 data_ok with rdata=32'h0000_000C while stall=1 for 3 cycles -> if_valid held 4 cycles with if_inst=0000000C; no new req until stall=0.
REQ-040 flush (flush_pc=8000_0180) in WAIT; stale data_ok 2 cycles later -> that data is never presented; next req addr 80000180.
REQ-041 flush in REQ with addr_ok delayed 2 cycles -> inst_addr stays at the old pc until addr_ok; response dropped; next req addr = flush_pc.
REQ-042 flush_pc=8000_0002 -> no req issued; if_valid=1, if_unaligned=1, if_inst=0 until the next flush.
REQ-043 pc=FFFF_FFFC fetch accepted -> next req addr 00000000.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared core definitions for the instruction fetch controller:
// FSM encoding, default reset vector and small PC helpers.
package inst_fetch_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DISCARD = 3'd3,
    ST_HOLD    = 3'd4
  } fetch_state_e;

  // Sequential successor; 32-bit addition wraps 0xFFFF_FFFC to 0.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic is_unaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM-like request at a time,
// single-word hold buffer under stall, and flush handling for in-flight fetches.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_unaligned
);

  fetch_state_e state_r, state_next_s;
  logic [31:0]  pc_r, pc_next_s;
  logic [31:0]  addr_r, addr_next_s;
  logic [31:0]  hold_r, hold_next_s;
  logic         drop_r, drop_next_s;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      hold_r  <= 32'h0000_0000;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      addr_r  <= addr_next_s;
      hold_r  <= hold_next_s;
      drop_r  <= drop_next_s;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    addr_next_s  = addr_r;
    hold_next_s  = hold_r;
    drop_next_s  = drop_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          pc_next_s   = flush_pc;
          hold_next_s = 32'h0000_0000;
        end else if (fetch_en && !is_unaligned(pc_r)) begin
          state_next_s = ST_REQ;
          addr_next_s  = pc_r;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // The request address is frozen in addr_r, so pc may retarget freely.
        if (flush) begin
          pc_next_s   = flush_pc;
          drop_next_s = 1'b1;
        end else begin
          drop_next_s = drop_r;
        end
        if (inst_addr_ok) begin
          state_next_s = (flush || drop_r) ? ST_DISCARD : ST_WAIT;
          drop_next_s  = 1'b0;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (inst_data_ok) begin
          if (flush) begin
            pc_next_s    = flush_pc;
            state_next_s = ST_IDLE;
          end else if (stall) begin
            hold_next_s  = inst_rdata;
            state_next_s = ST_HOLD;
          end else begin
            pc_next_s    = next_seq_pc(pc_r);
            state_next_s = ST_IDLE;
          end
        end else if (flush) begin
          pc_next_s    = flush_pc;
          state_next_s = ST_DISCARD;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        if (flush) begin
          pc_next_s = flush_pc;
        end else begin
          pc_next_s = pc_r;
        end
        if (inst_data_ok) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_next_s    = flush_pc;
          hold_next_s  = 32'h0000_0000;
          state_next_s = ST_IDLE;
        end else if (!stall) begin
          pc_next_s    = next_seq_pc(pc_r);
          hold_next_s  = 32'h0000_0000;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        drop_next_s  = 1'b0;
      end
    endcase
  end

  // Output decode; WAIT passes read data straight through to the pipeline.
  always_comb begin
    inst_req     = 1'b0;
    inst_addr    = addr_r;
    if_valid     = 1'b0;
    if_pc        = pc_r;
    if_inst      = 32'h0000_0000;
    if_unaligned = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_unaligned(pc_r) && !flush) begin
          if_valid     = 1'b1;
          if_unaligned = 1'b1;
        end else begin
          if_valid     = 1'b0;
          if_unaligned = 1'b0;
        end
      end
      ST_REQ: begin
        inst_req = 1'b1;
      end
      ST_WAIT: begin
        if (inst_data_ok && !flush) begin
          if_valid = 1'b1;
          if_inst  = inst_rdata;
        end else begin
          if_valid = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!flush) begin
          if_valid = 1'b1;
          if_inst  = hold_r;
        end else begin
          if_valid = 1'b0;
        end
      end
      default: begin
        if_valid = 1'b0;
      end
    endcase
  end

endmodule
